// File: rtl/ps2_mouse_host.sv
// ps2_mouse_host: PS/2 mouse host controller. Runs the command ROM (reset,
// optional IntelliMouse wheel unlock, enable reporting) with ACK checking,
// retries and timeouts, then assembles 3- or 4-byte movement packets.
//
// Handshakes:
//   tx_req/tx_byte : tx_req rises with tx_byte and both hold stable until a
//                    tx_done pulse is seen; tx_done while tx_req is low is
//                    ignored. At most one command is in flight.
//   rx_valid       : single-cycle strobe qualifying rx_frame; no backpressure.
module ps2_mouse_host #(
    parameter int WHEEL_EN   = 1,
    parameter int MAX_RETRY  = 3,
    parameter int TICK_DIV   = 2500,
    parameter int ACK_TICKS  = 200,
    parameter int BAT_TICKS  = 8000,
    parameter int BYTE_TICKS = 20
) (
    input  logic        qzt_clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  tx_byte,
    output logic        tx_req,
    input  logic        tx_done,
    input  logic [10:0] rx_frame,
    input  logic        rx_valid,
    output logic        pkt_valid,
    output logic [2:0]  buttons,
    output logic [8:0]  dx,
    output logic [8:0]  dy,
    output logic [3:0]  dz,
    output logic        x_ovf,
    output logic        y_ovf,
    output logic        wheel_mode,
    output logic        init_done,
    output logic        init_fail,
    output logic [7:0]  err_cnt,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_ACK, S_BAT, S_GET_ID, S_STREAM, S_FAIL
    } state_t;

    localparam int          ROM_LEN  = (WHEEL_EN != 0) ? 9 : 2;
    localparam logic [3:0]  ROM_LAST = 4'(ROM_LEN - 1);
    localparam logic [3:0]  IDX_F2   = 4'd7;
    localparam logic [7:0]  MAX_R    = 8'(MAX_RETRY);
    localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);
    localparam logic [13:0] ACK_LIM  = 14'(ACK_TICKS);
    localparam logic [13:0] BAT_LIM  = 14'(BAT_TICKS);
    localparam logic [13:0] BYTE_LIM = 14'(BYTE_TICKS);
    localparam logic [13:0] TICK_MAX = 14'h3FFF;

    state_t      state;
    logic        start_q;
    logic [3:0]  rom_idx;
    logic [7:0]  retry;
    logic        aa_seen;
    logic [1:0]  pkt_k;
    logic [7:0]  b0, b1, b2;
    logic [15:0] pre_cnt;
    logic [13:0] tick_cnt;

    logic [7:0]  rx_byte;
    logic        rx_ok;
    logic        retry_evt;
    logic [1:0]  pkt_last;
    logic [7:0]  err_next;

    assign dbg_state = state;
    assign pkt_last  = wheel_mode ? 2'd3 : 2'd2;
    assign err_next  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

    // Command ROM: FF, [F3 C8 F3 64 F3 50 F2], F4.
    function automatic logic [7:0] rom_byte(input logic [3:0] idx);
        logic [7:0] b;
        b = 8'hF4;
        if (idx == 4'd0) begin
            b = 8'hFF;
        end else if (WHEEL_EN != 0) begin
            case (idx)
                4'd1, 4'd3, 4'd5: b = 8'hF3;
                4'd2:             b = 8'hC8;
                4'd4:             b = 8'h64;
                4'd6:             b = 8'h50;
                4'd7:             b = 8'hF2;
                default:          b = 8'hF4;
            endcase
        end
        return b;
    endfunction

    // Frame decode: D0 sits at bit 9, odd parity over data+parity.
    always_comb begin
        for (int i = 0; i < 8; i++) rx_byte[i] = rx_frame[9-i];
        rx_ok = ~rx_frame[10] & rx_frame[0] & (^rx_frame[9:1]);
    end

    // Init-phase failures that cost one retry of the current command.
    always_comb begin
        retry_evt = 1'b0;
        case (state)
            S_WAIT_ACK: retry_evt = rx_valid ? (!rx_ok || rx_byte == 8'hFE || rx_byte == 8'hFC)
                                             : (tick_cnt >= ACK_LIM);
            S_BAT:      retry_evt = rx_valid ? (rx_ok && rx_byte == 8'hFC)
                                             : (tick_cnt >= BAT_LIM);
            S_GET_ID:   retry_evt = !rx_valid && (tick_cnt >= ACK_LIM);
            default:    retry_evt = 1'b0;
        endcase
    end

    // Main controller: timer, init FSM, packet assembly, registered outputs.
    always_ff @(posedge qzt_clk) begin
        if (rst) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            tx_byte    <= 8'h00;
            tx_req     <= 1'b0;
            pkt_valid  <= 1'b0;
            buttons    <= 3'd0;
            dx         <= 9'd0;
            dy         <= 9'd0;
            dz         <= 4'd0;
            x_ovf      <= 1'b0;
            y_ovf      <= 1'b0;
            wheel_mode <= 1'b0;
            init_done  <= 1'b0;
            init_fail  <= 1'b0;
            err_cnt    <= 8'd0;
            rom_idx    <= 4'd0;
            retry      <= 8'd0;
            aa_seen    <= 1'b0;
            pkt_k      <= 2'd0;
            b0         <= 8'd0;
            b1         <= 8'd0;
            b2         <= 8'd0;
            pre_cnt    <= 16'd0;
            tick_cnt   <= 14'd0;
        end else begin
            start_q   <= start;
            pkt_valid <= 1'b0;

            // 100 us tick timer; the clears further down take precedence.
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= 16'd0;
                if (tick_cnt != TICK_MAX) tick_cnt <= tick_cnt + 14'd1;
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end
            if (rx_valid) begin
                pre_cnt  <= 16'd0;
                tick_cnt <= 14'd0;
            end

            case (state)
                S_IDLE, S_FAIL: begin
                    if (start && !start_q) begin
                        state      <= S_SEND;
                        rom_idx    <= 4'd0;
                        retry      <= 8'd0;
                        init_fail  <= 1'b0;
                        wheel_mode <= 1'b0;
                        pre_cnt    <= 16'd0;
                        tick_cnt   <= 14'd0;
                    end
                end
                S_SEND: begin
                    if (!tx_req) begin
                        tx_req  <= 1'b1;
                        tx_byte <= rom_byte(rom_idx);
                    end else if (tx_done) begin
                        tx_req   <= 1'b0;
                        state    <= S_WAIT_ACK;
                        pre_cnt  <= 16'd0;
                        tick_cnt <= 14'd0;
                    end
                end
                S_WAIT_ACK: begin
                    if (rx_valid && rx_ok && rx_byte == 8'hFA) begin
                        retry <= 8'd0;
                        if (rom_idx == 4'd0) begin
                            state   <= S_BAT;
                            aa_seen <= 1'b0;
                        end else if (WHEEL_EN != 0 && rom_idx == IDX_F2) begin
                            state <= S_GET_ID;
                        end else if (rom_idx == ROM_LAST) begin
                            state     <= S_STREAM;
                            init_done <= 1'b1;
                            pkt_k     <= 2'd0;
                        end else begin
                            rom_idx <= rom_idx + 4'd1;
                            state   <= S_SEND;
                        end
                    end
                end
                S_BAT: begin
                    if (rx_valid && rx_ok) begin
                        if (rx_byte == 8'hAA) begin
                            aa_seen <= 1'b1;
                        end else if (rx_byte == 8'h00 && aa_seen) begin
                            rom_idx <= rom_idx + 4'd1;
                            state   <= S_SEND;
                        end
                    end
                end
                S_GET_ID: begin
                    if (rx_valid && rx_ok) begin
                        wheel_mode <= (WHEEL_EN != 0) && (rx_byte == 8'h03);
                        rom_idx    <= rom_idx + 4'd1;
                        state      <= S_SEND;
                    end
                end
                S_STREAM: begin
                    if (tx_req && tx_done) tx_req <= 1'b0;
                    if (rx_valid) begin
                        if (!rx_ok) begin
                            // Ask for a resend and restart packet alignment.
                            tx_req  <= 1'b1;
                            tx_byte <= 8'hFE;
                            pkt_k   <= 2'd0;
                            err_cnt <= err_next;
                        end else if (pkt_k == 2'd0) begin
                            if (rx_byte[3]) begin
                                b0    <= rx_byte;
                                pkt_k <= 2'd1;
                            end else begin
                                err_cnt <= err_next;
                            end
                        end else if (pkt_k == pkt_last) begin
                            buttons   <= b0[2:0];
                            x_ovf     <= b0[6];
                            y_ovf     <= b0[7];
                            dx        <= {b0[4], b1};
                            pkt_valid <= 1'b1;
                            pkt_k     <= 2'd0;
                            if (wheel_mode) begin
                                dy <= {b0[5], b2};
                                dz <= rx_byte[3:0];
                            end else begin
                                dy <= {b0[5], rx_byte};
                                dz <= 4'd0;
                            end
                        end else begin
                            if (pkt_k == 2'd1) b1 <= rx_byte;
                            else               b2 <= rx_byte;
                            pkt_k <= pkt_k + 2'd1;
                        end
                    end else if (pkt_k != 2'd0 && tick_cnt >= BYTE_LIM) begin
                        pkt_k    <= 2'd0;
                        err_cnt  <= err_next;
                        pre_cnt  <= 16'd0;
                        tick_cnt <= 14'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Failed ACK/BAT/ID: resend the same command or give up.
            if (retry_evt) begin
                pre_cnt  <= 16'd0;
                tick_cnt <= 14'd0;
                if (retry >= MAX_R) begin
                    state     <= S_FAIL;
                    init_fail <= 1'b1;
                end else begin
                    retry <= retry + 8'd1;
                    state <= S_SEND;
                end
            end
        end
    end

endmodule
